// File: rtl/score_display_pkg.sv
// Shared definitions for the score overlay: glyph geometry, conversion
// state encoding, a decimal-limit helper and the shared glyph ROM lookup.
package score_display_pkg;

    localparam int GLYPH_W     = 20;
    localparam int GLYPH_H     = 30;
    localparam int GLYPH_BYTES = 600;

    localparam logic [5:0] GLYPH_INK   = 6'h3C;
    localparam logic [5:0] GLYPH_PAPER = 6'h00;

    typedef enum logic {
        CONV_IDLE = 1'b0,
        CONV_RUN  = 1'b1
    } conv_state_e;

    // Largest value representable in n decimal digits: 10^n - 1.
    function automatic int max_value(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p - 1;
    endfunction

    // Shared combinational glyph ROM: seven-segment style digits 0-9,
    // addressed as digit*600 + y*20 + x.
    function automatic logic [5:0] glyph_rom(input logic [14:0] addr);
        int         a;
        int         d;
        int         off;
        int         x;
        int         y;
        logic [6:0] seg;
        logic       lit;
        a   = int'(addr);
        d   = a / GLYPH_BYTES;
        off = a % GLYPH_BYTES;
        y   = off / GLYPH_W;
        x   = off % GLYPH_W;
        case (d)
            0:       seg = 7'h3F;
            1:       seg = 7'h06;
            2:       seg = 7'h5B;
            3:       seg = 7'h4F;
            4:       seg = 7'h66;
            5:       seg = 7'h6D;
            6:       seg = 7'h7D;
            7:       seg = 7'h07;
            8:       seg = 7'h7F;
            9:       seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        lit = (seg[0] && y <= 3 && x >= 2 && x <= 17)
           || (seg[1] && x >= 16 && y >= 2 && y <= 14)
           || (seg[2] && x >= 16 && y >= 15 && y <= 27)
           || (seg[3] && y >= 26 && x >= 2 && x <= 17)
           || (seg[4] && x <= 3 && y >= 15 && y <= 27)
           || (seg[5] && x <= 3 && y >= 2 && y <= 14)
           || (seg[6] && y >= 13 && y <= 16 && x >= 2 && x <= 17);
        if (y >= GLYPH_H) lit = 1'b0;
        return lit ? GLYPH_INK : GLYPH_PAPER;
    endfunction

endpackage

// File: rtl/score_display_dabble.sv
// Iterative double-dabble binary-to-BCD converter. One adjust+shift per
// cycle; the result register only changes when a conversion completes,
// so consumers never see a partial value. A new load restarts at once.
module bcd_dabble
    import score_display_pkg::*;
#(
    parameter int VALUE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [VALUE_W-1:0]      value,
    output logic                    busy,
    output logic [4*NUM_DIGITS-1:0] result
);

    localparam int                BCD_W     = 4 * NUM_DIGITS;
    localparam int                SR_W      = BCD_W + VALUE_W;
    localparam int                CNT_W     = $clog2(VALUE_W + 1);
    localparam logic [31:0]       MAX_VAL   = 32'(max_value(NUM_DIGITS));
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(VALUE_W - 1);

    conv_state_e        state;
    logic [SR_W-1:0]    sr;
    logic [SR_W-1:0]    sr_next;
    logic [CNT_W-1:0]   iter;
    logic [VALUE_W-1:0] clamped;

    // Saturate inputs that do not fit in the displayed digit count.
    always_comb begin
        clamped = (32'(value) > MAX_VAL) ? MAX_VAL[VALUE_W-1:0] : value;
    end

    // One double-dabble step: add 3 to every nibble >= 5, then shift left.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        sr_next = sr;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sr_next[VALUE_W + 4*i +: 4] >= 4'd5)
                sr_next[VALUE_W + 4*i +: 4] = sr_next[VALUE_W + 4*i +: 4] + 4'd3;
        end
        sr_next = {sr_next[SR_W-2:0], 1'b0};
    end

    // Conversion sequencing; load has priority and aborts a running pass.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state  <= CONV_IDLE;
            sr     <= '0;
            iter   <= '0;
            result <= '0;
        end else if (load) begin
            state <= CONV_RUN;
            sr    <= {{BCD_W{1'b0}}, clamped};
            iter  <= '0;
        end else if (state == CONV_RUN) begin
            sr   <= sr_next;
            iter <= iter + 1'b1;
            if (iter == LAST_ITER) begin
                result <= sr_next[SR_W-1 -: BCD_W];
                state  <= CONV_IDLE;
            end
        end
    end

    assign busy = (state == CONV_RUN);

endmodule

// File: rtl/score_display.sv
// Decimal score overlay for the VGA pixel path. Converts a loaded binary
// value to BCD and composites NUM_DIGITS glyphs over the background.
// Optional feature macro: SCORE_DISPLAY_LZB_EN (leading-zero blanking).
module score_display
    import score_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int X0         = 100,
    parameter int Y0         = 100,
    parameter int DIG_W      = 20,
    parameter int DIG_H      = 30,
    parameter int PITCH      = 25,
    parameter int BLINK_BIT  = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [VALUE_W-1:0]      value,
    input  logic                    blink_en,
    input  logic                    visible,
    input  logic [9:0]              col,
    input  logic [9:0]              row,
    input  logic [5:0]              bg_rgb,
    output logic [5:0]              rgb_out,
    output logic                    digit_on,
    output logic                    busy,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    logic [BLINK_BIT:0]    blink_cnt;
    logic                  show;
    logic [NUM_DIGITS-1:0] blank;
    logic                  hit;
    logic                  hit_blank;
    logic [14:0]           glyph_addr;
    logic [5:0]            glyph_pix;

    bcd_dabble #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_dabble (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .value  (value),
        .busy   (busy),
        .result (bcd)
    );

    // Free-running blink phase counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) blink_cnt <= '0;
        else        blink_cnt <= blink_cnt + 1'b1;
    end

    assign show = !blink_en || blink_cnt[BLINK_BIT];

`ifdef SCORE_DISPLAY_LZB_EN
    logic lead_zero;

    // Blank each leading zero digit; the least-significant digit always shows.
    always_comb begin
        blank     = '0;
        lead_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            lead_zero = lead_zero && (bcd[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            blank[k]  = lead_zero && (k != NUM_DIGITS - 1);
        end
    end
`else
    assign blank = '0;
`endif

    // Find which digit box (if any) holds the pixel and form its glyph address.
    always_comb begin
        hit        = 1'b0;
        hit_blank  = 1'b0;
        glyph_addr = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (int'(col) >= X0 + k*PITCH && int'(col) < X0 + k*PITCH + DIG_W &&
                int'(row) >= Y0           && int'(row) < Y0 + DIG_H) begin
                hit        = 1'b1;
                hit_blank  = blank[k];
                glyph_addr = 15'(int'(bcd[4*(NUM_DIGITS-1-k) +: 4]) * GLYPH_BYTES
                                 + (int'(row) - Y0) * GLYPH_W
                                 + (int'(col) - X0 - k*PITCH));
            end
        end
    end

    assign glyph_pix = glyph_rom(glyph_addr);

    // Composite: black outside active video, glyph over background inside.
    always_comb begin
        if (!visible)                      rgb_out = 6'h00;
        else if (hit && show && !hit_blank) rgb_out = glyph_pix;
        else                               rgb_out = bg_rgb;
    end

    assign digit_on = visible && hit;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: randomized loads and pixel probes
// compared against a decimal/segment-level reference model.
module tb_score_display;

    localparam int ND    = 4;
    localparam int VW    = 14;
    localparam int X0    = 100;
    localparam int Y0    = 100;
    localparam int DW    = 20;
    localparam int DH    = 30;
    localparam int PITCH = 25;
    localparam int BB    = 3;
    localparam int MAXV  = 9999;
`ifdef SCORE_DISPLAY_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          load     = 1'b0;
    logic [VW-1:0] value    = '0;
    logic          blink_en = 1'b0;
    logic          visible  = 1'b0;
    logic [9:0]    col      = '0;
    logic [9:0]    row      = '0;
    logic [5:0]    bg_rgb   = '0;
    logic [5:0]    rgb_out;
    logic          digit_on;
    logic          busy;
    logic [4*ND-1:0] bcd;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          cyc       = 0;
    logic [15:0] model_bcd = '0;

    score_display #(
        .NUM_DIGITS (ND),
        .VALUE_W    (VW),
        .X0         (X0),
        .Y0         (Y0),
        .DIG_W      (DW),
        .DIG_H      (DH),
        .PITCH      (PITCH),
        .BLINK_BIT  (BB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .blink_en (blink_en),
        .visible  (visible),
        .col      (col),
        .row      (row),
        .bg_rgb   (bg_rgb),
        .rgb_out  (rgb_out),
        .digit_on (digit_on),
        .busy     (busy),
        .bcd      (bcd)
    );

    always #5 clk = ~clk;

    // Cycles elapsed since reset release, for the blink phase.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decimal digits of the saturated value, most significant nibble first.
    function automatic logic [15:0] ref_bcd(input int v);
        int          c;
        logic [15:0] r;
        c = (v > MAXV) ? MAXV : v;
        r = '0;
        for (int k = 0; k < ND; k++) begin
            r[4*k +: 4] = 4'(c % 10);
            c = c / 10;
        end
        return r;
    endfunction

    function automatic string segs_of(input int d);
        case (d)
            0: return "abcdef";
            1: return "bc";
            2: return "abdeg";
            3: return "abcdg";
            4: return "bcfg";
            5: return "acdfg";
            6: return "acdefg";
            7: return "abc";
            8: return "abcdefg";
            9: return "abcdfg";
            default: return "";
        endcase
    endfunction

    function automatic bit in_seg(input byte s, input int x, input int y);
        case (s)
            "a": return y < 4 && x >= 2 && x < 18;
            "b": return x >= 16 && y >= 2 && y < 15;
            "c": return x >= 16 && y >= 15 && y < 28;
            "d": return y >= 26 && x >= 2 && x < 18;
            "e": return x < 4 && y >= 15 && y < 28;
            "f": return x < 4 && y >= 2 && y < 15;
            "g": return y >= 13 && y < 17 && x >= 2 && x < 18;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [5:0] glyph_ref(input int d, input int x, input int y);
        string s;
        s = segs_of(d);
        for (int i = 0; i < s.len(); i++)
            if (in_seg(s[i], x, y)) return 6'h3C;
        return 6'h00;
    endfunction

    function automatic logic [5:0] exp_rgb(input int c, input int r, input bit vis,
                                           input logic [5:0] bg, input bit show);
        bit lead;
        bit blank;
        int d;
        int xl;
        lead = 1'b1;
        if (!vis) return 6'h00;
        for (int k = 0; k < ND; k++) begin
            d     = int'((model_bcd >> (4*(ND-1-k))) & 16'hF);
            lead  = lead && (d == 0);
            blank = LZB && lead && (k < ND - 1);
            xl    = X0 + k*PITCH;
            if (c >= xl && c < xl + DW && r >= Y0 && r < Y0 + DH)
                return (show && !blank) ? glyph_ref(d, c - xl, r - Y0) : bg;
        end
        return bg;
    endfunction

    function automatic bit exp_on(input int c, input int r, input bit vis);
        for (int k = 0; k < ND; k++)
            if (c >= X0 + k*PITCH && c < X0 + k*PITCH + DW && r >= Y0 && r < Y0 + DH)
                return vis;
        return 1'b0;
    endfunction

    task automatic pix(input int c, input int r, input bit vis, input logic [5:0] bg,
                       input bit show, input string tag);
        col = 10'(c); row = 10'(r); visible = vis; bg_rgb = bg;
        #1;
        check({tag, "_rgb"}, 32'(rgb_out), 32'(exp_rgb(c, r, vis, bg, show)));
        check({tag, "_on"}, 32'(digit_on), 32'(exp_on(c, r, vis)));
    endtask

    // Waits for busy to drop, noting whether bcd ever left its old value.
    task automatic wait_done(input logic [15:0] old, output int cycles, output bit held);
        cycles = 0;
        held   = 1'b1;
        while (busy === 1'b1 && cycles < 100) begin
            if (bcd !== old) held = 1'b0;
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic run_conv(input int v, input string tag);
        int          cycles;
        bit          held;
        logic [15:0] old;
        old = model_bcd;
        @(negedge clk); load = 1'b1; value = VW'(v);
        @(negedge clk); load = 1'b0;
        wait_done(old, cycles, held);
        model_bcd = ref_bcd(v);
        check({tag, "_busy_cycles"}, 32'(cycles), 32'(VW));
        check({tag, "_hold"}, 32'(held), 32'd1);
        check({tag, "_bcd"}, 32'(bcd), 32'(model_bcd));
    endtask

    initial begin
        int          cycles;
        bit          held;
        logic [15:0] old;
        int          seen_ink;
        int          seen_bg;
        int          vals[6];

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        pix(X0 + 5, Y0 + 5, 1'b0, 6'h2A, 1'b1, "rst_invis");
        pix(0, 0, 1'b1, 6'h2A, 1'b1, "rst_bg");
        pix(X0 + 3*PITCH + 10, Y0 + 1, 1'b1, 6'h11, 1'b1, "rst_lsd");

        // Basic conversion and saturation
        run_conv(1234, "c1234");
        run_conv(12345, "c12345");

        // Reload while busy: first conversion must never surface
        old = model_bcd;
        held = 1'b1;
        @(negedge clk); load = 1'b1; value = VW'(4321);
        @(negedge clk); load = 1'b0;
        if (bcd !== old || busy !== 1'b1) held = 1'b0;
        @(negedge clk);
        if (bcd !== old) held = 1'b0;
        @(negedge clk); load = 1'b1; value = VW'(55);
        if (bcd !== old) held = 1'b0;
        @(negedge clk); load = 1'b0;
        check("abort_hold_pre", 32'(held), 32'd1);
        wait_done(old, cycles, held);
        model_bcd = ref_bcd(55);
        check("abort_busy_cycles", 32'(cycles), 32'(VW));
        check("abort_hold", 32'(held), 32'd1);
        check("abort_bcd", 32'(bcd), 32'h0055);

        // Full scan around all digit boxes with a single-digit value
        run_conv(7, "c7");
        for (int r = Y0 - 2; r < Y0 + DH + 2; r++)
            for (int c = X0 - 2; c < X0 + 3*PITCH + DW + 2; c++)
                pix(c, r, 1'b1, 6'h15, 1'b1, "scan7");

        // Boundary and random values with random pixel probes
        vals = '{0, MAXV, MAXV + 1, (1 << VW) - 1, 0, 0};
        vals[4] = int'($urandom_range(0, (1 << VW) - 1));
        vals[5] = int'($urandom_range(0, 999));
        for (int i = 0; i < 6; i++) begin
            run_conv(vals[i], "cfix");
            for (int p = 0; p < 150; p++)
                pix(X0 - 5 + int'($urandom_range(0, 4*PITCH + 10)),
                    Y0 - 5 + int'($urandom_range(0, DH + 10)),
                    ($urandom_range(0, 7) != 0), 6'($urandom), 1'b1, "rnd");
        end
        for (int i = 0; i < 6; i++) begin
            run_conv(int'($urandom_range(0, (1 << VW) - 1)), "crnd");
            for (int p = 0; p < 100; p++)
                pix(X0 - 5 + int'($urandom_range(0, 4*PITCH + 10)),
                    Y0 - 5 + int'($urandom_range(0, DH + 10)),
                    ($urandom_range(0, 7) != 0), 6'($urandom), 1'b1, "rnd2");
        end

        // Reset in the middle of a conversion
        @(negedge clk); load = 1'b1; value = VW'(4321);
        @(negedge clk); load = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_bcd", 32'(bcd), 32'd0);
        model_bcd = '0;
        @(negedge clk); rst_n = 1'b1;

        // Blink: hidden for the first phase, then alternating every 2^BB cycles
        blink_en = 1'b1;
        seen_ink = 0;
        seen_bg  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            pix(X0 + 3*PITCH + 10, Y0 + 1, 1'b1, 6'h05, ((cyc >> BB) & 1) != 0, "blink");
            if (rgb_out === 6'h3C) seen_ink++;
            if (rgb_out === 6'h05) seen_bg++;
            if (i == 5) check("blink_hidden_early", 32'(rgb_out), 32'h05);
        end
        check("blink_both_phases", 32'(seen_ink > 0 && seen_bg > 0), 32'd1);
        pix(X0 + 3*PITCH + 10, Y0 + 1, 1'b0, 6'h05, 1'b1, "blink_invis");
        check("midrst_no_update_bcd", 32'(bcd), 32'd0);
        check("midrst_no_update_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/score_display.md
# score_display

Multi-digit decimal number overlay for the VGA pixel path. Captures a binary value on a load strobe, converts it to BCD with an iterative double-dabble engine, and composites `NUM_DIGITS` 20×30 glyph sprites over the incoming background colour at a configurable screen position. Optional blinking and saturation are included. It sits between the background/scene generator and the VGA output mux, and generalises the fixed two-digit dividend overlay to any digit count and any binary input.

## Interface
- `NUM_DIGITS`, 4: number of displayed decimal digits (1–6).
- `VALUE_W`, 14: width of the binary input value (1–20).
- `X0`, 100: column of the top-left corner of the most-significant digit.
- `Y0`, 100: row of the top edge of all digits.
- `DIG_W`, 20: glyph width in pixels (fixed by the glyph ROM).
- `DIG_H`, 30: glyph height in pixels (fixed by the glyph ROM).
- `PITCH`, 25: horizontal distance between the left edges of adjacent digits (≥ `DIG_W`).
- `BLINK_BIT`, 24: bit of the free-running blink counter that gates visibility.

Ports:
- `clk` in 1: pixel clock; the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `load` in 1: single-cycle strobe; samples `value`.
- `value` in `VALUE_W`: binary value to display.
- `blink_en` in 1: 1 = digits blink; 0 = digits always shown.
- `visible` in 1: active video region.
- `col`, `row` in 10 each: current pixel coordinate.
- `bg_rgb` in 6: background colour.
- `rgb_out` out 6: composited colour.
- `digit_on` out 1: current pixel lies inside some digit box and `visible` is 1.
- `busy` out 1: conversion in progress.
- `bcd` out `4*NUM_DIGITS`: currently displayed digits, most significant nibble first.

## Operation
- Load capture: when `load` is 1 and the block is idle or busy, `value` is clamped to MAX = 10^NUM_DIGITS − 1 and loaded into the shift register with all BCD nibbles zeroed. The iteration count resets to 0 and `busy` is set to 1.
- Load while busy: the conversion in progress is aborted and a new one starts from the new value. `bcd` keeps its old contents.
- Conversion (states IDLE → CONV → IDLE): each CONV cycle adds 3 to every BCD nibble ≥ 5, then shifts the combined register left by 1. After `VALUE_W` iterations, `bcd` is updated with the result in one cycle, `busy` returns to 0, and the state returns to IDLE.
- Display reads only `bcd`. It never reads the in-flight register, so a digit never shows a partial value.
- Digit k (k = 0 is most significant) occupies columns X0+k·PITCH to X0+k·PITCH+DIG_W−1 and rows Y0 to Y0+DIG_H−1.
- Glyph address = d·600 + (row−Y0)·20 + (col−X0−k·PITCH), where d is the digit value. The address is 15 bits wide and is decoded with the shared combinational glyph ROM.
- Blink: a free-running counter, `BLINK_BIT`+1 bits wide, resets to 0. The display gate is `show = !blink_en || counter[BLINK_BIT]`.
- Pixel output:
  - If `visible` is 0, `rgb_out` = 0.
  - Otherwise, if `show` is 1 and the pixel is inside an unblanked digit, `rgb_out` = glyph pixel.
  - Otherwise, `rgb_out` = `bg_rgb`.
- `digit_on` is not gated by blink or blanking.

## Timing
- Reset values: `bcd` = 0, `busy` = 0, state IDLE, blink counter 0.
  - Consequently, after reset `rgb_out` = 0 outside visible video and `bg_rgb` elsewhere until glyphs are shown.
- Reset asserted mid-conversion aborts it immediately. `bcd` returns to 0.
- `load` sampled at edge E0:
  - `busy` is 1 after E0.
  - `bcd` is updated at edge E(VALUE_W), and `busy` goes to 0 at the same edge.
- Pixel path: `rgb_out` and `digit_on` are combinational in `col`/`row`/`bg_rgb`/`visible`/`bcd`, with zero cycles of latency.
- The blink phase toggles every 2^BLINK_BIT cycles. While `blink_en` = 1, digits are hidden for the first 2^BLINK_BIT cycles after reset.

## Configuration
- `SCORE_DISPLAY_LZB_EN`:
  - Defined: leading-zero blanking. Digit k is drawn as background when all digits 0..k are zero. The least-significant digit is never blanked, so a value of 0 shows a single "0".
  - Undefined: all `NUM_DIGITS` digits are always drawn, including leading zeros.

## Structure
- Shared package `score_display_pkg`:
  - glyph constants GLYPH_W = 20, GLYPH_H = 30, GLYPH_BYTES = 600;
  - the conversion-state enum;
  - a function returning 10^n − 1.
- Sub-module `bcd_dabble`: iterative binary-to-BCD converter with `load`/`busy`/result ports, parameterised by `VALUE_W` and `NUM_DIGITS`.
- The glyph lookup reuses the existing glyph ROM.

## Test plan
- Reset, then `load` with `value` = 1234 (NUM_DIGITS = 4, VALUE_W = 14) → `busy` is high for exactly 14 cycles, then `bcd` = 16'h1234.
- `value` = 12345 → clamped: `bcd` = 16'h9999.
- With LZB_EN, `value` = 7 and `blink_en` = 0; scan pixel (X0+3·25+x, Y0+y) → glyph "7" pixels. Pixels in digits 0–2 equal `bg_rgb`, while `digit_on` = 1 there.
- Load 4321, then load 55 three cycles later → final `bcd` = 16'h0055 at 14 cycles after the second load; 4321 never appears.
- Assert `rst_n` = 0 mid-conversion → `busy` = 0 and `bcd` = 0 immediately; no update follows.
- `blink_en` = 1, BLINK_BIT = 3 → glyph pixels alternate with background every 8 cycles. Outside `visible`, `rgb_out` = 0.
